// File: rtl/iccm_boot_loader_if.sv
// ICCM word-write port driven by the UART boot loader.
// The master side issues one-cycle write strobes with address and data;
// the slave side is the ICCM write port that commits them.
interface iccm_boot_loader_if #(
  parameter int AddrW = 14
);

  logic             we;     // one-cycle write strobe
  logic [AddrW-1:0] addr;   // word address, valid with we
  logic [31:0]      wdata;  // write data, valid with we

  modport master (
    output we,
    output addr,
    output wdata
  );

  modport slave (
    input we,
    input addr,
    input wdata
  );

endinterface

// File: rtl/iccm_boot_loader.sv
// Framed UART boot loader.
// Accepts a frame of SyncByte, 16-bit little-endian word count, 4*N payload
// bytes and an 8-bit additive checksum. Payload bytes are packed
// little-endian into 32-bit words and written sequentially to the ICCM from
// word address 0. The system is held in reset from the sync byte until a
// frame completes with a good checksum; length, checksum and inter-byte
// timeout failures are reported on a sticky error code.
module iccm_boot_loader #(
  parameter int         AddrW         = 14,
  parameter int         MaxWords      = 4096,
  parameter logic [7:0] SyncByte      = 8'hA5,
  parameter int         TimeoutCycles = 2000000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_dv_i,
  input  logic [7:0]          rx_byte_i,
  iccm_boot_loader_if.master  iccm,
  output logic                reset_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          err_o
);

  // Timer counts idle cycles 0 .. TimeoutCycles-1; hitting the last value
  // without a byte is the timeout.
  localparam int              TmrW    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_CSUM    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  state_e           state_q;
  logic [15:0]      len_q;     // requested word count
  logic [AddrW-1:0] addr_q;    // address of the word being assembled
  logic [1:0]       idx_q;     // byte lane within the current word
  logic [7:0]       csum_q;    // running wrap-around payload sum
  logic [23:0]      word_q;    // lanes 0..2 of the word being assembled
  logic [TmrW-1:0]  tmr_q;     // idle cycles since the last accepted byte

  logic [15:0]      len_next;
  logic             len_bad;
  logic             last_word;
  logic             in_frame;
  logic             sync_seen;

  // Full length as it will be once the high byte currently on rx_byte_i is taken.
  assign len_next  = {rx_byte_i, len_q[7:0]};
  assign len_bad   = (len_next == 16'd0) || (32'(len_next) > 32'(MaxWords));
  // The word being completed is the final one of the frame.
  assign last_word = (32'(addr_q) + 32'd1) == 32'(len_q);
  assign in_frame  = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign sync_seen = rx_dv_i && (rx_byte_i == SyncByte);

  // Frame parser, word packer, inter-byte timer and all registered outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch of
    // the clocked block; every register including the datapath is cleared so
    // an abandoned frame leaves no stale address or data on the write port.
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      word_q      <= '0;
      tmr_q       <= '0;
      iccm.we     <= 1'b0;
      iccm.addr   <= '0;
      iccm.wdata  <= '0;
      reset_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= ERR_NONE;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // sees the pre-edge register values regardless of statement order.
      iccm.we <= 1'b0;

      // Inter-byte timeout: a byte in the expiry cycle wins over the timeout.
      if (in_frame) begin
        if (rx_dv_i) begin
          tmr_q <= '0;
        end else if (tmr_q == TmrLast) begin
          state_q <= ST_ERR;
          busy_o  <= 1'b0;
          err_o   <= ERR_TIMEOUT;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
      end

      // Byte-driven transitions; nothing below acts without rx_dv_i.
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (sync_seen) begin
            state_q <= ST_LEN_LO;
            tmr_q   <= '0;
            reset_o <= 1'b1;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            err_o   <= ERR_NONE;
          end
        end

        ST_LEN_LO: begin
          if (rx_dv_i) begin
            len_q[7:0] <= rx_byte_i;
            state_q    <= ST_LEN_HI;
          end
        end

        ST_LEN_HI: begin
          if (rx_dv_i) begin
            len_q[15:8] <= rx_byte_i;
            if (len_bad) begin
              state_q <= ST_ERR;
              busy_o  <= 1'b0;
              err_o   <= ERR_LEN;
            end else begin
              addr_q  <= '0;
              csum_q  <= '0;
              idx_q   <= '0;
              state_q <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (rx_dv_i) begin
            csum_q <= csum_q + rx_byte_i;
            idx_q  <= idx_q + 2'd1;
            case (idx_q)
              2'd0: word_q[7:0]   <= rx_byte_i;
              2'd1: word_q[15:8]  <= rx_byte_i;
              2'd2: word_q[23:16] <= rx_byte_i;
              default: begin
                // Fourth byte completes the word: strobe it out next cycle.
                iccm.we    <= 1'b1;
                iccm.addr  <= addr_q;
                iccm.wdata <= {rx_byte_i, word_q};
                addr_q     <= addr_q + 1'b1;
                if (last_word) begin
                  state_q <= ST_CSUM;
                end
              end
            endcase
          end
        end

        ST_CSUM: begin
          if (rx_dv_i) begin
            busy_o <= 1'b0;
            if (rx_byte_i == csum_q) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
              reset_o <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_o   <= ERR_CSUM;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Bench for iccm_boot_loader: directed frames checked every cycle against a
// byte-position frame model, plus literal expectations for key results.
module tb_iccm_boot_loader;

  localparam int AddrW   = 14;
  localparam int MaxW    = 4096;
  localparam int Timeout = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       reset_o, busy_o, done_o;
  logic [1:0] err_o;

  iccm_boot_loader_if #(.AddrW(AddrW)) bus ();

  iccm_boot_loader #(
    .AddrW(AddrW), .MaxWords(MaxW), .SyncByte(8'hA5), .TimeoutCycles(Timeout)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
    .iccm(bus.master), .reset_o(reset_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  bit          armed = 1'b0;
  bit          m_in, m_reset, m_done, m_we;
  logic [1:0]  m_err;
  int          m_pos, m_len, m_silent;
  logic [7:0]  m_sum;
  logic [31:0] m_word, m_wdata;
  logic [13:0] m_addr;
  logic [31:0] m_log_addr[$], m_log_data[$];
  logic [31:0] d_log_addr[$], d_log_data[$];

  // Interpret one accepted byte by its position within the frame.
  task automatic model_byte(input logic [7:0] b);
    int i;
    if (m_pos == 0) begin
      m_len = int'(b);
    end else if (m_pos == 1) begin
      m_len = m_len + 256 * int'(b);
      m_sum = 8'd0;
      if (m_len == 0 || m_len > MaxW) begin
        m_in  = 1'b0;
        m_err = 2'd1;
      end
    end else if (m_pos < 2 + 4 * m_len) begin
      i = m_pos - 2;
      m_word[8*(i%4) +: 8] = b;
      m_sum = m_sum + b;
      if (i % 4 == 3) begin
        m_we    = 1'b1;
        m_addr  = 14'(i / 4);
        m_wdata = m_word;
        m_log_addr.push_back(32'(m_addr));
        m_log_data.push_back(m_wdata);
      end
    end else begin
      m_in = 1'b0;
      if (b == m_sum) begin
        m_done  = 1'b1;
        m_reset = 1'b0;
      end else begin
        m_err = 2'd2;
      end
    end
    m_pos++;
  endtask

  always @(posedge clk) begin
    m_we = 1'b0;
    if (!rst_n) begin
      armed = 1'b1;
      m_in = 1'b0; m_reset = 1'b0; m_done = 1'b0; m_err = 2'd0;
      m_addr = '0; m_wdata = '0;
    end else if (m_in) begin
      if (rx_dv) begin
        m_silent = 0;
        model_byte(rx_byte);
      end else begin
        m_silent++;
        if (m_silent == Timeout) begin
          m_in  = 1'b0;
          m_err = 2'd3;
        end
      end
    end else if (rx_dv && rx_byte == 8'hA5) begin
      m_in = 1'b1; m_pos = 0; m_silent = 0;
      m_reset = 1'b1; m_done = 1'b0; m_err = 2'd0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      check("we",    32'(bus.we),    32'(m_we));
      check("addr",  32'(bus.addr),  32'(m_addr));
      check("wdata", bus.wdata,      m_wdata);
      check("busy",  32'(busy_o),    32'(m_in));
      check("reset", 32'(reset_o),   32'(m_reset));
      check("done",  32'(done_o),    32'(m_done));
      check("err",   32'(err_o),     32'(m_err));
      if (bus.we === 1'b1) begin
        d_log_addr.push_back(32'(bus.addr));
        d_log_data.push_back(bus.wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] txq[$];

  // Called at a negedge; returns at the next negedge with rx_dv low.
  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    foreach (txq[k]) begin
      send_byte(txq[k]);
      idle(1);
    end
    txq.delete();
  endtask

  task automatic check_log(input string name, input int n, input logic [31:0] a, input logic [31:0] d);
    if (d_log_data.size() > n && m_log_data.size() > n) begin
      check({name, "_dut_addr"},   d_log_addr[n], a);
      check({name, "_dut_data"},   d_log_data[n], d);
      check({name, "_model_data"}, m_log_data[n], d);
    end else begin
      check({name, "_log_size"}, 32'(d_log_data.size()), 32'(n + 1));
    end
  endtask

  int nw;

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    idle(3);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_reset", 32'(reset_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Test 1: single word
    txq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    flush();
    check("t1_reset_in_frame", 32'(reset_o), 32'd1);
    txq = '{8'hAA};
    flush();
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_err", 32'(err_o), 32'd0);
    check("t1_reset_released", 32'(reset_o), 32'd0);
    check_log("t1_w0", 0, 32'd0, 32'h44332211);

    // Test 2: three words, checksum 0x42
    txq = '{8'hA5, 8'h03, 8'h00};
    for (int k = 0; k < 12; k++) txq.push_back(8'(k));
    txq.push_back(8'h42);
    flush();
    check("t2_done", 32'(done_o), 32'd1);
    check_log("t2_w0", 1, 32'd0, 32'h03020100);
    check_log("t2_w1", 2, 32'd1, 32'h07060504);
    check_log("t2_w2", 3, 32'd2, 32'h0B0A0908);

    // Test 3: bad checksum, then recovery
    txq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    flush();
    check("t3_err", 32'(err_o), 32'd2);
    check("t3_reset_held", 32'(reset_o), 32'd1);
    check("t3_done", 32'(done_o), 32'd0);
    check_log("t3_w0", 4, 32'd0, 32'h44332211);
    txq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    flush();
    check("t3_recover_done", 32'(done_o), 32'd1);
    check("t3_recover_err", 32'(err_o), 32'd0);

    // Test 4: bad lengths, no writes
    nw = d_log_data.size();
    txq = '{8'hA5, 8'h00, 8'h00};
    flush();
    check("t4_len0_err", 32'(err_o), 32'd1);
    check("t4_len0_busy", 32'(busy_o), 32'd0);
    txq = '{8'hA5, 8'h01, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
    flush();
    check("t4_lenmax_err", 32'(err_o), 32'd1);
    check("t4_no_writes", 32'(d_log_data.size()), 32'(nw));

    // Test 5: timeout after the 2nd data byte, then a byte on the last cycle
    txq = '{8'hA5, 8'h02, 8'h00, 8'h01};
    flush();
    send_byte(8'h02);
    idle(15);
    check("t5_not_yet", 32'(err_o), 32'd0);
    idle(1);
    check("t5_timeout_err", 32'(err_o), 32'd3);
    check("t5_timeout_busy", 32'(busy_o), 32'd0);
    txq = '{8'hA5, 8'h01, 8'h00, 8'h01};
    flush();
    send_byte(8'h02);
    idle(15);
    send_byte(8'h03);
    idle(1);
    txq = '{8'h04, 8'h0A};
    flush();
    check("t5_edge_done", 32'(done_o), 32'd1);
    check("t5_edge_err", 32'(err_o), 32'd0);

    // Test 6: reset mid-DATA, junk before sync
    txq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
    flush();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_reset", 32'(reset_o), 32'd0);
    check("t6_done", 32'(done_o), 32'd0);
    check("t6_wdata", bus.wdata, 32'd0);
    txq = '{8'h11, 8'h5A, 8'h00};
    flush();
    check("t6_junk_ignored", 32'(busy_o), 32'd0);
    txq = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
    flush();
    check("t6_done_after", 32'(done_o), 32'd1);
    check("t6_last_wdata", bus.wdata, 32'hEFBEADDE);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
